vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, the next generation of our fixed 12 MHz timing block. Every horizontal and vertical segment and both sync polarities are parameters, and an integer pixel-clock prescaler is built in. Adds run/hold control, line/frame start strobes and a frame counter. All outputs are registered and mutually aligned. Feeds pixel-address logic, block-RAM framebuffer readers and test-pattern generators.

---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_pix_ce_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA raster timing definitions.
//   - vga_timing_t          : one complete horizontal/vertical segment set
//   - VGA_384X525           : 384x525 total raster, 12 MHz pixel clock
//   - VGA_640X480           : 640x480 visible, 800x525 total, 25.175 MHz
//   - clog2()               : ceiling log2, usable in constant expressions
//   - h_total()/v_total()   : sum of the four segments of one axis
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_384X525 = '{
    h_active: 305, h_fp: 10, h_sync: 46, h_bp: 23,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };
  localparam int unsigned VGA_384X525_PCLK_HZ = 12_000_000;

  localparam vga_timing_t VGA_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };
  localparam int unsigned VGA_640X480_PCLK_HZ = 25_175_000;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_ce_div.sv
// vga_pix_ce_div: integer prescaler producing one advance per CLK_DIV enabled cycles.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (counter to 0)
//   en_i   : count enable; low holds the count
//   adv_o  : combinational, high on the enabled cycle where the count is CLK_DIV-1
module vga_pix_ce_div
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic adv_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    adv_o = en_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = adv_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   CLK, RST      : clock, synchronous active-high reset
//   en            : run enable; low freezes all timing state
//   pix_ce        : one-CLK pulse following each pixel advance
//   h_counter     : pixel column 0..H_TOTAL-1
//   v_counter     : line 0..V_TOTAL-1
//   hsync, vsync  : sync pulses, asserted level set by *_SYNC_POL
//   visible_range : inside the active area
//   line_start    : pulse in the pix_ce cycle of column 0
//   frame_start   : pulse in the pix_ce cycle of (0,0)
//   frame_count   : completed frames, wrapping
// All outputs are registered from the same next-state values, so they are
// mutually aligned with the counters they describe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_384X525.h_active,
  parameter int unsigned H_FP       = VGA_384X525.h_fp,
  parameter int unsigned H_SYNC     = VGA_384X525.h_sync,
  parameter int unsigned H_BP       = VGA_384X525.h_bp,
  parameter int unsigned V_ACTIVE   = VGA_384X525.v_active,
  parameter int unsigned V_FP       = VGA_384X525.v_fp,
  parameter int unsigned V_SYNC     = VGA_384X525.v_sync,
  parameter int unsigned V_BP       = VGA_384X525.v_bp,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned H_BITS     = 10,
  parameter int unsigned V_BITS     = 10,
  parameter int unsigned FRAME_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  output logic                  pix_ce,
  output logic [H_BITS-1:0]     h_counter,
  output logic [V_BITS-1:0]     v_counter,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  visible_range,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [FRAME_BITS-1:0] frame_count
);

  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // One extra bit so bounds equal to 2^BITS still compare correctly.
  localparam logic [H_BITS:0]   H_ACT_W    = (H_BITS+1)'(H_ACTIVE);
  localparam logic [H_BITS:0]   HS_START_W = (H_BITS+1)'(HS_START);
  localparam logic [H_BITS:0]   HS_END_W   = (H_BITS+1)'(HS_END);
  localparam logic [V_BITS:0]   V_ACT_W    = (V_BITS+1)'(V_ACTIVE);
  localparam logic [V_BITS:0]   VS_START_W = (V_BITS+1)'(VS_START);
  localparam logic [V_BITS:0]   VS_END_W   = (V_BITS+1)'(VS_END);
  localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_seg
    $fatal(1, "vga_timing_gen: H_SYNC, V_SYNC, H_ACTIVE, V_ACTIVE must be >= 1");
  end
  if ((64'd1 << H_BITS) < 64'(H_TOTAL)) begin : g_bad_hbits
    $fatal(1, "vga_timing_gen: H_BITS too small for H_TOTAL");
  end
  if ((64'd1 << V_BITS) < 64'(V_TOTAL)) begin : g_bad_vbits
    $fatal(1, "vga_timing_gen: V_BITS too small for V_TOTAL");
  end

  logic adv;

  vga_pix_ce_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk_i(CLK),
    .rst_i(RST),
    .en_i (en),
    .adv_o(adv)
  );

  logic [H_BITS-1:0]     h_q, h_d;
  logic [V_BITS-1:0]     v_q, v_d;
  logic                  hs_q, hs_d, vs_q, vs_d, vis_q, vis_d;
  logic                  pce_q, pce_d, ls_q, ls_d, fs_q, fs_d;
  logic [FRAME_BITS-1:0] fc_q, fc_d;
  // Set by reset; the frame reached by the first advance is not counted.
  logic                  first_q, first_d;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    vis_d   = vis_q;
    fc_d    = fc_q;
    first_d = first_q;
    pce_d   = adv;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      hs_d  = (({1'b0, h_d} >= HS_START_W) && ({1'b0, h_d} < HS_END_W)) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d  = (({1'b0, v_d} >= VS_START_W) && ({1'b0, v_d} < VS_END_W)) ? V_SYNC_POL : ~V_SYNC_POL;
      vis_d = ({1'b0, h_d} < H_ACT_W) && ({1'b0, v_d} < V_ACT_W);
      ls_d  = (h_d == '0);
      fs_d  = (h_d == '0) && (v_d == '0);
      if (fs_d && !first_q) fc_d = fc_q + 1'b1;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      vis_q   <= 1'b0;
      pce_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vis_q   <= vis_d;
      pce_q   <= pce_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
      first_q <= first_d;
    end
  end

  assign pix_ce        = pce_q;
  assign h_counter     = h_q;
  assign v_counter     = v_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign visible_range = vis_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // A: defaults.  B: CLK_DIV=2, positive syncs.  C: tiny raster 8x7.
  logic rstA = 1'b1, enA = 1'b0, rstB = 1'b1, enB = 1'b0, rstC = 1'b1, enC = 1'b0;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic [2:0] c_h, c_v;
  logic [7:0] a_fc, b_fc, c_fc;
  logic a_pce, a_hs, a_vs, a_vis, a_ls, a_fs;
  logic b_pce, b_hs, b_vs, b_vis, b_ls, b_fs;
  logic c_pce, c_hs, c_vs, c_vis, c_ls, c_fs;

  vga_timing_gen dA (
    .CLK(CLK), .RST(rstA), .en(enA), .pix_ce(a_pce), .h_counter(a_h), .v_counter(a_v),
    .hsync(a_hs), .vsync(a_vs), .visible_range(a_vis), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc));

  vga_timing_gen #(.CLK_DIV(2), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dB (
    .CLK(CLK), .RST(rstB), .en(enB), .pix_ce(b_pce), .h_counter(b_h), .v_counter(b_v),
    .hsync(b_hs), .vsync(b_vs), .visible_range(b_vis), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .H_BITS(3), .V_BITS(3), .FRAME_BITS(8)) dC (
    .CLK(CLK), .RST(rstC), .en(enC), .pix_ce(c_pce), .h_counter(c_h), .v_counter(c_v),
    .hsync(c_hs), .vsync(c_vs), .visible_range(c_vis), .line_start(c_ls),
    .frame_start(c_fs), .frame_count(c_fc));

  typedef struct {
    int h; int v; bit hs; bit vs; bit vis; bit pce; bit ls; bit fs; int fc;
  } obs_t;

  typedef struct {
    string tag; bit rst; bit en; obs_t exp;
  } vec_t;

  int n_vec = 0, n_err = 0, cyc = 0, cur = 0;
  obs_t expq[$];
  obs_t last, dflt;

  // Reference model configuration and state
  int m_ha, m_va, m_ht, m_vt, m_hss, m_hse, m_vss, m_vse, m_div, m_pre;
  bit m_hpol, m_vpol, m_first;
  obs_t m_o;

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit vis, bit pce, bit ls, bit fs, int fc);
    obs_t o;
    o.h = h; o.v = v; o.hs = hs; o.vs = vs; o.vis = vis; o.pce = pce; o.ls = ls; o.fs = fs; o.fc = fc;
    return o;
  endfunction

  function automatic vec_t mkv(string tag, bit rst, bit en, obs_t e);
    vec_t r;
    r.tag = tag; r.rst = rst; r.en = en; r.exp = e;
    return r;
  endfunction

  function automatic obs_t get_obs(int sel);
    case (sel)
      0: return mk(int'(a_h), int'(a_v), a_hs, a_vs, a_vis, a_pce, a_ls, a_fs, int'(a_fc));
      1: return mk(int'(b_h), int'(b_v), b_hs, b_vs, b_vis, b_pce, b_ls, b_fs, int'(b_fc));
      default: return mk(int'(c_h), int'(c_v), c_hs, c_vs, c_vis, c_pce, c_ls, c_fs, int'(c_fc));
    endcase
  endfunction

  function automatic bit same(obs_t a, obs_t b);
    return a.h == b.h && a.v == b.v && a.hs == b.hs && a.vs == b.vs && a.vis == b.vis &&
           a.pce == b.pce && a.ls == b.ls && a.fs == b.fs && a.fc == b.fc;
  endfunction

  task automatic set_cfg(input int sel, input int ha, input int hfp, input int hs, input int hbp,
                         input int va, input int vfp, input int vs, input int vbp,
                         input bit hpol, input bit vpol, input int div);
    cur = sel;
    m_ha = ha; m_va = va;
    m_ht = ha + hfp + hs + hbp; m_vt = va + vfp + vs + vbp;
    m_hss = ha + hfp; m_hse = ha + hfp + hs;
    m_vss = va + vfp; m_vse = va + vfp + vs;
    m_hpol = hpol; m_vpol = vpol; m_div = div;
  endtask

  task automatic model_step(input bit rst, input bit en);
    if (rst) begin
      m_pre = 0; m_first = 1'b1;
      m_o = mk(m_ht - 1, m_vt - 1, !m_hpol, !m_vpol, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end else begin
      m_o.pce = 1'b0; m_o.ls = 1'b0; m_o.fs = 1'b0;
      if (en) begin
        if (m_pre == m_div - 1) begin
          m_pre = 0;
          m_o.pce = 1'b1;
          m_o.h = (m_o.h + 1) % m_ht;
          if (m_o.h == 0) m_o.v = (m_o.v + 1) % m_vt;
          m_o.hs = (m_o.h >= m_hss && m_o.h < m_hse) ? m_hpol : !m_hpol;
          m_o.vs = (m_o.v >= m_vss && m_o.v < m_vse) ? m_vpol : !m_vpol;
          m_o.vis = (m_o.h < m_ha) && (m_o.v < m_va);
          m_o.ls = (m_o.h == 0);
          m_o.fs = (m_o.h == 0) && (m_o.v == 0);
          if (m_o.fs && !m_first) m_o.fc = (m_o.fc + 1) % 256;
          m_first = 1'b0;
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  endtask

  task automatic drive(input bit rst, input bit en);
    rstA = (cur == 0) ? rst : 1'b1;  enA = (cur == 0) ? en : 1'b0;
    rstB = (cur == 1) ? rst : 1'b1;  enB = (cur == 1) ? en : 1'b0;
    rstC = (cur == 2) ? rst : 1'b1;  enC = (cur == 2) ? en : 1'b0;
  endtask

  // One CLK: drive, push expectation, sample #1 after the edge, pop and compare.
  task automatic tick(input bit rst, input bit en, input bit use_exp, input obs_t ex, input string tag);
    obs_t e, got;
    drive(rst, en);
    model_step(rst, en);
    expq.push_back(use_exp ? ex : m_o);
    @(posedge CLK);
    #1;
    cyc++;
    e = expq.pop_front();
    got = get_obs(cur);
    last = got;
    n_vec++;
    if (!same(got, e)) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got h=%0d v=%0d hs=%0b vs=%0b vis=%0b pce=%0b ls=%0b fs=%0b fc=%0d; want h=%0d v=%0d hs=%0b vs=%0b vis=%0b pce=%0b ls=%0b fs=%0b fc=%0d",
               tag, cyc, got.h, got.v, got.hs, got.vs, got.vis, got.pce, got.ls, got.fs, got.fc,
               e.h, e.v, e.hs, e.vs, e.vis, e.pce, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    bit found;
    int hs_cnt, hmin, hmax, ls_n, prev, vis_n, c0, pce_n, ls_run, ls_max, vmin, vmax;

    dflt = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- A: defaults, reset and first advance ----------------
    set_cfg(0, 305, 10, 46, 23, 480, 10, 2, 33, 1'b0, 1'b0, 1);
    tbl[0] = mkv("rst0",  1'b1, 1'b1, mk(383, 524, 1, 1, 0, 0, 0, 0, 0));
    tbl[1] = mkv("rst1",  1'b1, 1'b1, mk(383, 524, 1, 1, 0, 0, 0, 0, 0));
    tbl[2] = mkv("rst2",  1'b1, 1'b1, mk(383, 524, 1, 1, 0, 0, 0, 0, 0));
    tbl[3] = mkv("first", 1'b0, 1'b1, mk(0,   0,   1, 1, 1, 1, 1, 1, 0));
    tbl[4] = mkv("h1",    1'b0, 1'b1, mk(1,   0,   1, 1, 1, 1, 0, 0, 0));
    tbl[5] = mkv("h2",    1'b0, 1'b1, mk(2,   0,   1, 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 6; i++) tick(tbl[i].rst, tbl[i].en, 1'b1, tbl[i].exp, tbl[i].tag);

    // Two full lines starting at h=3
    hs_cnt = 0; hmin = 9999; hmax = -1; ls_n = 0; prev = -1; vis_n = 0;
    for (int i = 0; i < 768; i++) begin
      tick(1'b0, 1'b1, 1'b0, dflt, "a_line");
      if (!last.hs) begin
        hs_cnt++;
        if (last.h < hmin) hmin = last.h;
        if (last.h > hmax) hmax = last.h;
      end
      if (last.vis) vis_n++;
      if (last.ls) begin
        ls_n++;
        if (prev >= 0) check_int("a_ls_spacing", cyc - prev, 384);
        prev = cyc;
      end
    end
    check_int("a_hsync_low_cnt", hs_cnt, 92);
    check_int("a_hsync_first_h", hmin, 315);
    check_int("a_hsync_last_h", hmax, 360);
    check_int("a_ls_count", ls_n, 2);
    check_int("a_visible_cnt", vis_n, 610);
    check_int("a_v_after_2lines", last.v, 2);

    // en held low for 7 cycles at h=100
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin tick(1'b0, 1'b1, 1'b0, dflt, "a_seek_ls"); found = last.ls; end
    check_int("a_find_ls", int'(found), 1);
    c0 = cyc;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin tick(1'b0, 1'b1, 1'b0, dflt, "a_seek_h100"); found = (last.h == 100); end
    check_int("a_find_h100", int'(found), 1);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, dflt, "a_hold");
    check_int("a_hold_h", last.h, 100);
    tick(1'b0, 1'b1, 1'b0, dflt, "a_resume");
    check_int("a_resume_h", last.h, 101);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin tick(1'b0, 1'b1, 1'b0, dflt, "a_seek_ls2"); found = last.ls; end
    check_int("a_find_ls2", int'(found), 1);
    check_int("a_stretched_line", cyc - c0, 391);

    // ---------------- B: CLK_DIV=2, positive syncs ----------------
    set_cfg(1, 305, 10, 46, 23, 480, 10, 2, 33, 1'b1, 1'b1, 2);
    tick(1'b1, 1'b1, 1'b0, dflt, "b_rst");
    tick(1'b1, 1'b1, 1'b0, dflt, "b_rst");
    c0 = cyc;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(1'b0, 1'b1, 1'b0, dflt, "b_start"); found = last.ls; end
    check_int("b_first_ls_latency", cyc - c0, 2);
    hs_cnt = int'(last.hs); pce_n = int'(last.pce); ls_n = int'(last.ls); ls_run = int'(last.ls); ls_max = ls_run;
    for (int i = 0; i < 767; i++) begin
      tick(1'b0, 1'b1, 1'b0, dflt, "b_line");
      if (last.hs) hs_cnt++;
      if (last.pce) pce_n++;
      if (last.ls) begin ls_n++; ls_run++; end else ls_run = 0;
      if (ls_run > ls_max) ls_max = ls_run;
    end
    check_int("b_hsync_high_clks", hs_cnt, 92);
    check_int("b_pix_ce_count", pce_n, 384);
    check_int("b_ls_count", ls_n, 1);
    check_int("b_ls_width", ls_max, 1);
    for (int i = 0; i < 300; i++) tick(1'b0, ($urandom_range(0, 3) != 0), 1'b0, dflt, "b_rand_en");

    // ---------------- C: 8x7 raster, frame-level behaviour ----------------
    set_cfg(2, 4, 1, 2, 1, 3, 1, 2, 1, 1'b0, 1'b0, 1);
    tick(1'b1, 1'b1, 1'b0, dflt, "c_rst");
    tick(1'b1, 1'b1, 1'b0, dflt, "c_rst");
    tick(1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1, 0), "c_first");
    for (int f = 1; f <= 2; f++) begin
      c0 = cyc; hs_cnt = 0; vmin = 99; vmax = -1;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        tick(1'b0, 1'b1, 1'b0, dflt, "c_frame");
        if (!last.vs) begin
          hs_cnt++;
          if (last.v < vmin) vmin = last.v;
          if (last.v > vmax) vmax = last.v;
        end
        found = last.fs;
      end
      check_int("c_frame_len", cyc - c0, 56);
      check_int("c_frame_count", last.fc, f);
      if (f == 1) begin
        check_int("c_vsync_low_clks", hs_cnt, 16);
        check_int("c_vsync_first_v", vmin, 4);
        check_int("c_vsync_last_v", vmax, 5);
      end
    end
    found = 0;
    for (int i = 0; i < 256 * 56 + 200 && !found; i++) begin
      tick(1'b0, 1'b1, 1'b0, dflt, "c_to255");
      found = last.fs && (last.fc == 255);
    end
    check_int("c_reach_255", int'(found), 1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin tick(1'b0, 1'b1, 1'b0, dflt, "c_wrap"); found = last.fs; end
    check_int("c_fc_wrap", last.fc, 0);
    for (int i = 0; i < 150; i++) tick(1'b0, ($urandom_range(0, 2) != 0), 1'b0, dflt, "c_rand_en");

    // Reset in mid-frame
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1'b0, 1'b1, 1'b0, dflt, "c_seek_mid");
      found = (last.v == 3) && (last.h == 5);
    end
    check_int("c_find_mid", int'(found), 1);
    tick(1'b1, 1'b1, 1'b1, mk(7, 6, 1, 1, 0, 0, 0, 0, 0), "c_mid_rst");
    tick(1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1, 0), "c_restart");
    for (int i = 0; i < 120; i++) tick(1'b0, 1'b1, 1'b0, dflt, "c_after_rst");
    check_int("c_fc_after_rst", last.fc, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
